// File: rtl/ecc_sed_pkg.sv
// Shared definitions for the single-error-detect (even parity) codeword path.
// Used by both the SED encoder and the checker.
package ecc_sed_pkg;

  localparam int DATA_W = 12;
  localparam int CW_W   = DATA_W + 1;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } sed_entry_t;

  function automatic logic sed_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ecc_sed_fifo2.sv
// Generic 2-entry valid/ready buffer. The head register drives the output
// directly, so the output stays stable while it is stalled.
module ecc_sed_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         full,
  output logic         empty
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e         occ, occ_nxt;
  logic [W-1:0] head_q, tail_q;
  logic         push, pop;

  assign full     = (occ == OCC_FULL);
  assign empty    = (occ == OCC_EMPTY);
  assign out_data = head_q;
  assign push     = in_valid && !full;
  assign pop      = !empty && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= OCC_EMPTY;
    else        occ <= occ_nxt;
  end

  always_comb begin
    occ_nxt = occ;
    unique case (occ)
      OCC_EMPTY: if (push) occ_nxt = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      occ_nxt = OCC_FULL;
        else if (pop && !push) occ_nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) occ_nxt = OCC_ONE;
      default:   occ_nxt = OCC_EMPTY;
    endcase
  end

  // Head is never cleared on pop: an empty buffer keeps showing its last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case (occ)
        OCC_EMPTY: if (push) head_q <= in_data;
        OCC_ONE: begin
          if (push && pop) head_q <= in_data;
          else if (push)   tail_q <= in_data;
        end
        OCC_FULL:  if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ecc_sed_checker.sv
// Even-parity checker for {parity, data} codewords with a 2-entry output
// buffer, optional dropping of failing words and saturating error status.
module ecc_sed_checker #(
  parameter int DATA_W   = ecc_sed_pkg::DATA_W,
  parameter int CNT_W    = 8,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [DATA_W:0]   enc_codeword,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sticky,
  input  logic              err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            syndrome, keep, accept, bad_accept;
  logic            fifo_full, fifo_empty;
  logic [DATA_W:0] fifo_out;

  assign syndrome   = ^enc_codeword;
  assign keep       = !(DROP_ERR && syndrome);
  assign enc_ready  = !fifo_full && rst;
  assign accept     = enc_valid && enc_ready;
  assign bad_accept = accept && syndrome;

  ecc_sed_fifo2 #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (enc_valid && keep && rst),
    .in_data   ({syndrome && !DROP_ERR, enc_codeword[DATA_W-1:0]}),
    .out_ready (dec_ready),
    .out_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dec_valid = !fifo_empty;
  assign dec_err   = fifo_out[DATA_W];
  assign dec_data  = fifo_out[DATA_W-1:0];

  // A failing accept outranks err_clr: the clear is applied, then the new event counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (bad_accept) begin
      err_sticky <= 1'b1;
      if (err_clr)                   err_count <= CNT_W'(1);
      else if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
    end else if (err_clr) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ecc_sed_checker.sv
// Scoreboard bench for ecc_sed_checker: default, saturating (CNT_W=4) and
// dropping (DROP_ERR=1) instances share one clock and reset.
module tb_ecc_sed_checker;
  import ecc_sed_pkg::*;

  logic clk, rst;
  int   n_chk, n_fail;

  // default instance
  logic            m_enc_valid, m_enc_ready, m_dec_valid, m_dec_ready, m_dec_err, m_err_sticky, m_err_clr;
  logic [CW_W-1:0] m_enc_codeword;
  logic [11:0]     m_dec_data;
  logic [7:0]      m_err_count;
  // saturation instance
  logic            s_enc_valid, s_enc_ready, s_dec_valid, s_dec_ready, s_dec_err, s_err_sticky, s_err_clr;
  logic [CW_W-1:0] s_enc_codeword;
  logic [11:0]     s_dec_data;
  logic [3:0]      s_err_count;
  // drop instance
  logic            d_enc_valid, d_enc_ready, d_dec_valid, d_dec_ready, d_dec_err, d_err_sticky, d_err_clr;
  logic [CW_W-1:0] d_enc_codeword;
  logic [11:0]     d_dec_data;
  logic [7:0]      d_err_count;

  sed_entry_t q_m[$];
  sed_entry_t q_d[$];
  logic [7:0] exp_cnt_m;
  logic       exp_sticky_m;

  ecc_sed_checker u_main (
    .clk(clk), .rst(rst), .enc_valid(m_enc_valid), .enc_ready(m_enc_ready),
    .enc_codeword(m_enc_codeword), .dec_valid(m_dec_valid), .dec_ready(m_dec_ready),
    .dec_data(m_dec_data), .dec_err(m_dec_err), .err_count(m_err_count),
    .err_sticky(m_err_sticky), .err_clr(m_err_clr)
  );

  ecc_sed_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .enc_valid(s_enc_valid), .enc_ready(s_enc_ready),
    .enc_codeword(s_enc_codeword), .dec_valid(s_dec_valid), .dec_ready(s_dec_ready),
    .dec_data(s_dec_data), .dec_err(s_dec_err), .err_count(s_err_count),
    .err_sticky(s_err_sticky), .err_clr(s_err_clr)
  );

  ecc_sed_checker #(.DROP_ERR(1'b1)) u_drop (
    .clk(clk), .rst(rst), .enc_valid(d_enc_valid), .enc_ready(d_enc_ready),
    .enc_codeword(d_enc_codeword), .dec_valid(d_dec_valid), .dec_ready(d_dec_ready),
    .dec_data(d_dec_data), .dec_err(d_dec_err), .err_count(d_err_count),
    .err_sticky(d_err_sticky), .err_clr(d_err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [CW_W-1:0] good_cw(input logic [11:0] d);
    return {sed_parity(d), d};
  endfunction

  function automatic logic [CW_W-1:0] bad_cw(input logic [11:0] d);
    return {~sed_parity(d), d};
  endfunction

  // Checks the default instance against the model, then advances one cycle.
  task automatic step_m();
    sed_entry_t exp;
    n_chk++;
    if (m_enc_ready !== (q_m.size() < 2)) begin
      n_fail++; $display("FAIL enc_ready: got %b expected %b", m_enc_ready, q_m.size() < 2);
    end
    n_chk++;
    if (m_dec_valid !== (q_m.size() != 0)) begin
      n_fail++; $display("FAIL dec_valid: got %b expected %b", m_dec_valid, q_m.size() != 0);
    end
    n_chk++;
    if (m_err_count !== exp_cnt_m || m_err_sticky !== exp_sticky_m) begin
      n_fail++;
      $display("FAIL err_status: got cnt=%0d sticky=%b expected cnt=%0d sticky=%b",
               m_err_count, m_err_sticky, exp_cnt_m, exp_sticky_m);
    end
    if (m_dec_valid && m_dec_ready && q_m.size() != 0) begin
      exp = q_m.pop_front();
      n_chk++;
      if ({m_dec_err, m_dec_data} !== exp) begin
        n_fail++;
        $display("FAIL dec_out: got err=%b data=%h expected err=%b data=%h",
                 m_dec_err, m_dec_data, exp.err, exp.data);
      end
    end
    if (m_enc_valid && m_enc_ready) begin
      q_m.push_back('{err: ^m_enc_codeword, data: m_enc_codeword[11:0]});
      if (^m_enc_codeword) begin
        exp_sticky_m = 1'b1;
        if (exp_cnt_m != 8'hFF) exp_cnt_m++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_m(input logic [CW_W-1:0] cw);
    bit done;
    done = 1'b0;
    m_enc_valid = 1'b1;
    m_enc_codeword = cw;
    for (int i = 0; i < 20 && !done; i++) begin
      done = m_enc_ready;
      step_m();
    end
    m_enc_valid = 1'b0;
    n_chk++;
    if (!done) begin
      n_fail++; $display("FAIL send_timeout: got accepted=0 expected accepted=1 (cw=%h)", cw);
    end
  endtask

  task automatic drain_m();
    for (int i = 0; i < 10 && q_m.size() != 0; i++) step_m();
    step_m();
    n_chk++;
    if (q_m.size() != 0) begin
      n_fail++; $display("FAIL drain: got %0d pending expected 0", q_m.size());
    end
  endtask

  task automatic step_d();
    sed_entry_t exp;
    if (d_dec_valid && d_dec_ready) begin
      n_chk++;
      if (q_d.size() == 0) begin
        n_fail++; $display("FAIL drop_extra: got data=%h expected no output", d_dec_data);
      end else begin
        exp = q_d.pop_front();
        if ({d_dec_err, d_dec_data} !== exp) begin
          n_fail++;
          $display("FAIL drop_out: got err=%b data=%h expected err=%b data=%h",
                   d_dec_err, d_dec_data, exp.err, exp.data);
        end
      end
    end
    if (d_enc_valid && d_enc_ready && !(^d_enc_codeword))
      q_d.push_back('{err: 1'b0, data: d_enc_codeword[11:0]});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({m_dec_valid, m_dec_data, m_dec_err, m_err_count, m_err_sticky, m_enc_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b data=%h err=%b cnt=%0d sticky=%b ready=%b expected all 0",
               m_dec_valid, m_dec_data, m_dec_err, m_err_count, m_err_sticky, m_enc_ready);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (m_enc_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 1", m_enc_ready);
    end
  endtask

  task automatic test_clean_stream();
    m_dec_ready = 1'b1;
    send_m(good_cw(12'h000));
    send_m(good_cw(12'hABC));
    send_m(good_cw(12'hFFF));
    drain_m();
  endtask

  task automatic test_flips();
    m_dec_ready = 1'b1;
    send_m({1'b0, 12'h001});
    send_m({1'b0, 12'h003});
    drain_m();
    n_chk++;
    if (m_err_count !== 8'd1 || m_err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL flip_count: got cnt=%0d sticky=%b expected cnt=1 sticky=1", m_err_count, m_err_sticky);
    end
  endtask

  task automatic test_back_to_back();
    m_dec_ready = 1'b0;
    send_m(good_cw(12'h111));
    send_m(good_cw(12'h222));
    m_enc_valid = 1'b1;
    m_enc_codeword = good_cw(12'h333);
    for (int i = 0; i < 3; i++) step_m();
    n_chk++;
    if (m_enc_ready !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_ready: got %b expected 0", m_enc_ready);
    end
    m_dec_ready = 1'b1;
    send_m(good_cw(12'h333));
    drain_m();
  endtask

  task automatic test_saturation();
    s_dec_ready = 1'b1;
    s_enc_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_enc_codeword = bad_cw(12'(i * 37));
      @(posedge clk); @(negedge clk);
    end
    s_enc_valid = 1'b0;
    n_chk++;
    if (s_err_count !== 4'd15 || s_err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL sat_count: got cnt=%0d sticky=%b expected cnt=15 sticky=1", s_err_count, s_err_sticky);
    end
    s_err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    s_err_clr = 1'b0;
    n_chk++;
    if (s_err_count !== 4'd0 || s_err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL clr_alone: got cnt=%0d sticky=%b expected cnt=0 sticky=0", s_err_count, s_err_sticky);
    end
    s_enc_valid = 1'b1;
    s_enc_codeword = bad_cw(12'h5A5);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (s_err_count !== 4'd2) begin
      n_fail++; $display("FAIL sat_recount: got cnt=%0d expected cnt=2", s_err_count);
    end
    s_err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    s_err_clr = 1'b0;
    s_enc_valid = 1'b0;
    n_chk++;
    if (s_err_count !== 4'd1 || s_err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL clr_with_err: got cnt=%0d sticky=%b expected cnt=1 sticky=1", s_err_count, s_err_sticky);
    end
  endtask

  task automatic test_drop();
    logic [CW_W-1:0] words [3];
    words[0] = good_cw(12'h123);
    words[1] = bad_cw(12'h7A5);
    words[2] = good_cw(12'h456);
    d_dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_enc_valid = 1'b1;
      d_enc_codeword = words[i];
      step_d();
    end
    d_enc_valid = 1'b0;
    for (int i = 0; i < 6; i++) step_d();
    n_chk++;
    if (q_d.size() != 0) begin
      n_fail++; $display("FAIL drop_missing: got %0d pending expected 0", q_d.size());
    end
    n_chk++;
    if (d_err_count !== 8'd1 || d_err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL drop_count: got cnt=%0d sticky=%b expected cnt=1 sticky=1", d_err_count, d_err_sticky);
    end
  endtask

  task automatic test_reset_mid();
    m_dec_ready = 1'b0;
    send_m(good_cw(12'h321));
    send_m(bad_cw(12'h0F0));
    #1 rst = 1'b0;
    #1;
    n_chk++;
    if (m_dec_valid !== 1'b0 || m_err_count !== 8'd0 || m_err_sticky !== 1'b0 || m_enc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b cnt=%0d sticky=%b ready=%b expected 0 0 0 0",
               m_dec_valid, m_err_count, m_err_sticky, m_enc_ready);
    end
    q_m.delete();
    exp_cnt_m = '0;
    exp_sticky_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (m_enc_ready !== 1'b1 || m_dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got ready=%b valid=%b expected ready=1 valid=0", m_enc_ready, m_dec_valid);
    end
    m_dec_ready = 1'b1;
    send_m(good_cw(12'h2A5));
    drain_m();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    exp_cnt_m = '0; exp_sticky_m = 1'b0;
    rst = 1'b0;
    {m_enc_valid, m_dec_ready, m_err_clr} = '0; m_enc_codeword = '0;
    {s_enc_valid, s_dec_ready, s_err_clr} = '0; s_enc_codeword = '0;
    {d_enc_valid, d_dec_ready, d_err_clr} = '0; d_enc_codeword = '0;
    test_reset();
    test_clean_stream();
    test_flips();
    test_back_to_back();
    test_saturation();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
